// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline. It tracks destinations through E/M/W
// and produces forwarding selects, load-use and multi-cycle stalls, and branch flushes.

module pipe_hazard_fwd #(
  parameter int RA_W      = 4,
  parameter int NOFWD_REG = 15
) (
  input  logic [RA_W-1:0] i_ra,
  input  logic            i_use,
  input  logic [RA_W-1:0] i_wa_m,
  input  logic            i_rw_m,
  input  logic [RA_W-1:0] i_wa_w,
  input  logic            i_rw_w,
  output logic [1:0]      o_sel
);
  logic w_nofwd;
  assign w_nofwd = (i_ra == RA_W'(NOFWD_REG));

  // M is younger than W, so it has priority.
  always_comb begin
    o_sel = 2'b00;
    if (i_use && !w_nofwd) begin
      if (i_rw_m && (i_wa_m == i_ra))      o_sel = 2'b10;
      else if (i_rw_w && (i_wa_w == i_ra)) o_sel = 2'b01;
    end
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int RA_W      = 4,
  parameter int NRD       = 2,
  parameter int MAX_LAT   = 4,
  parameter int NOFWD_REG = 15,
  localparam int LW       = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*RA_W-1:0] ra_d,
  input  logic [NRD-1:0]      ra_use_d,
  input  logic [RA_W-1:0]     wa_d,
  input  logic                regwrite_d,
  input  logic                memtoreg_d,
  input  logic [LW-1:0]       lat_d,
  input  logic                branch_taken_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                stall_e,
  output logic                bubble_m,
  output logic [2*NRD-1:0]    forward_e
);
  logic [NRD-1:0][RA_W-1:0] w_ra_d;
  logic [NRD-1:0]           w_hit_d;
  logic [LW-1:0]            w_lat_n;
  logic                     w_stall_e, w_lu, w_br, w_flush_e;

  logic [NRD-1:0][RA_W-1:0] r_ra_e;
  logic [NRD-1:0]           r_use_e;
  logic [RA_W-1:0]          r_wa_e, r_wa_m, r_wa_w;
  logic                     r_rw_e, r_ld_e, r_rw_m, r_rw_w;
  logic [LW-1:0]            r_cnt_e;

  assign w_ra_d = ra_d;

  always_comb begin
    w_lat_n = lat_d;
    if (lat_d == '0)                w_lat_n = LW'(1);
    else if (lat_d > LW'(MAX_LAT))  w_lat_n = LW'(MAX_LAT);
  end

  assign w_stall_e = (r_cnt_e != '0);
  assign w_lu      = r_ld_e & r_rw_e & ~w_stall_e & (|w_hit_d);
  assign w_br      = branch_taken_e & ~w_stall_e;
  assign w_flush_e = w_br | w_lu;

  // A taken branch wins over load-use so the PC redirect is not held off.
  assign stall_f  = w_stall_e | (w_lu & ~w_br);
  assign stall_d  = w_stall_e | (w_lu & ~w_br);
  assign flush_d  = w_br;
  assign flush_e  = w_flush_e;
  assign stall_e  = w_stall_e;
  assign bubble_m = w_stall_e;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    assign w_hit_d[g] = ra_use_d[g] && (w_ra_d[g] == r_wa_e);

    pipe_hazard_fwd #(.RA_W(RA_W), .NOFWD_REG(NOFWD_REG)) u_fwd (
      .i_ra   (r_ra_e[g]),
      .i_use  (r_use_e[g]),
      .i_wa_m (r_wa_m),
      .i_rw_m (r_rw_m),
      .i_wa_w (r_wa_w),
      .i_rw_w (r_rw_w),
      .o_sel  (forward_e[2*g +: 2])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ra_e  <= '0;
      r_use_e <= '0;
      r_wa_e  <= '0;
      r_rw_e  <= 1'b0;
      r_ld_e  <= 1'b0;
      r_cnt_e <= '0;
      r_wa_m  <= '0;
      r_rw_m  <= 1'b0;
      r_wa_w  <= '0;
      r_rw_w  <= 1'b0;
    end else begin
      r_wa_w <= r_wa_m;
      r_rw_w <= r_rw_m;
      if (w_stall_e) begin
        // E holds its instruction; M sees a bubble each busy cycle.
        r_cnt_e <= r_cnt_e - 1'b1;
        r_rw_m  <= 1'b0;
      end else begin
        r_wa_m <= r_wa_e;
        r_rw_m <= r_rw_e;
        if (w_flush_e) begin
          r_use_e <= '0;
          r_rw_e  <= 1'b0;
          r_ld_e  <= 1'b0;
          r_cnt_e <= '0;
        end else begin
          r_ra_e  <= w_ra_d;
          r_use_e <= ra_use_d;
          r_wa_e  <= wa_d;
          r_rw_e  <= regwrite_d;
          r_ld_e  <= memtoreg_d;
          r_cnt_e <= w_lat_n - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cycle table, reset/multi-cycle sequences,
// and random traffic checked against an instruction-level pipeline model.

module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ra_d;
  logic [1:0] ra_use_d;
  logic [3:0] wa_d;
  logic       regwrite_d, memtoreg_d, branch_taken_e;
  logic [2:0] lat_d;
  logic       stall_f, stall_d, flush_d, flush_e, stall_e, bubble_m;
  logic [3:0] forward_e;
  logic [5:0] ctl;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [5:0] C0 = 6'b000000;
  localparam logic [5:0] LU = 6'b110100;
  localparam logic [5:0] BR = 6'b001100;
  localparam logic [5:0] ST = 6'b110011;

  pipe_hazard_ctrl #(.RA_W(4), .NRD(2), .MAX_LAT(4), .NOFWD_REG(15)) dut (
    .clk(clk), .reset(reset), .ra_d(ra_d), .ra_use_d(ra_use_d), .wa_d(wa_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .lat_d(lat_d),
    .branch_taken_e(branch_taken_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_e(stall_e), .bubble_m(bubble_m),
    .forward_e(forward_e)
  );

  always #5 clk = ~clk;
  assign ctl = {stall_f, stall_d, flush_d, flush_e, stall_e, bubble_m};

  typedef struct {
    logic [3:0] ra0, ra1;
    logic [1:0] u;
    logic [3:0] wa;
    logic       rw, ld;
    logic [2:0] lat;
    logic       br;
    logic [5:0] ectl;
    logic [3:0] efwd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int ra0, int ra1, int u, int wa, int rw, int ld,
                              int lat, int br, logic [5:0] ec, logic [3:0] ef);
    vec_t v;
    v.ra0 = 4'(ra0); v.ra1 = 4'(ra1); v.u = 2'(u); v.wa = 4'(wa);
    v.rw = 1'(rw); v.ld = 1'(ld); v.lat = 3'(lat); v.br = 1'(br);
    v.ectl = ec; v.efwd = ef;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ra_d = {v.ra1, v.ra0}; ra_use_d = v.u; wa_d = v.wa;
    regwrite_d = v.rw; memtoreg_d = v.ld; lat_d = v.lat; branch_taken_e = v.br;
  endtask

  task automatic chk(input string nm, input logic [5:0] ec, input logic [3:0] ef);
    n_chk++;
    if ({ctl, forward_e} !== {ec, ef}) begin
      n_fail++;
      $display("FAIL %s: ctl=%b fwd=%b, expected ctl=%b fwd=%b", nm, ctl, forward_e, ec, ef);
    end
  endtask

  // Instruction-level model: E holds an instruction with a count of cycles left in E.
  typedef struct { logic [3:0] ra0, ra1, wa; bit u0, u1, rw, ld; int left; } m_e_t;
  typedef struct { logic [3:0] wa; bit rw; } m_wb_t;
  m_e_t  me;
  m_wb_t mm, mw;

  function automatic logic [1:0] mfwd(logic [3:0] ra, bit u);
    if (!u || ra == 4'd15)          return 2'b00;
    if (mm.rw && mm.wa == ra)       return 2'b10;
    if (mw.rw && mw.wa == ra)       return 2'b01;
    return 2'b00;
  endfunction

  function automatic int rreg();
    return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    vec_t NOP;
    NOP = mk(0,0,0, 0,0,0,1,0, C0, 4'b0000);
    // back-to-back ALU forwarding
    vt.push_back(mk(0,0,0, 3,1,0,1,0, C0, 4'b0000));
    vt.push_back(mk(3,0,1, 4,1,0,1,0, C0, 4'b0000));
    vt.push_back(mk(0,3,2, 6,1,0,1,0, C0, 4'b0010));
    vt.push_back(mk(0,0,0, 0,0,0,1,0, C0, 4'b0100));
    vt.push_back(NOP); vt.push_back(NOP);
    // load-use on port1
    vt.push_back(mk(0,0,0, 5,1,1,1,0, C0, 4'b0000));
    vt.push_back(mk(0,5,2, 7,1,0,1,0, LU, 4'b0000));
    vt.push_back(mk(0,5,2, 7,1,0,1,0, C0, 4'b0000));
    vt.push_back(mk(0,0,0, 0,0,0,1,0, C0, 4'b0100));
    vt.push_back(NOP); vt.push_back(NOP);
    // latency 3 then dependent instruction
    vt.push_back(mk(0,0,0, 8,1,0,3,0, C0, 4'b0000));
    vt.push_back(mk(8,0,1, 9,1,0,1,0, ST, 4'b0000));
    vt.push_back(mk(8,0,1, 9,1,0,1,0, ST, 4'b0000));
    vt.push_back(mk(8,0,1, 9,1,0,1,0, C0, 4'b0000));
    vt.push_back(mk(0,0,0, 0,0,0,1,0, C0, 4'b0010));
    vt.push_back(NOP); vt.push_back(NOP);
    // branch beats load-use; branch ignored while busy
    vt.push_back(mk(0,0,0, 5,1,1,1,0, C0, 4'b0000));
    vt.push_back(mk(5,0,1, 7,1,0,1,1, BR, 4'b0000));
    vt.push_back(NOP); vt.push_back(NOP);
    vt.push_back(mk(0,0,0, 8,1,0,3,0, C0, 4'b0000));
    vt.push_back(mk(0,0,0, 0,0,0,1,1, ST, 4'b0000));
    vt.push_back(mk(0,0,0, 0,0,0,1,0, ST, 4'b0000));
    vt.push_back(NOP); vt.push_back(NOP);
    // r15 never forwarded; lat 0 -> 1, lat 7 -> 4
    vt.push_back(mk(0,0,0, 15,1,0,1,0, C0, 4'b0000));
    vt.push_back(mk(15,15,3, 1,1,0,1,0, C0, 4'b0000));
    vt.push_back(NOP);
    vt.push_back(mk(0,0,0, 2,1,0,0,0, C0, 4'b0000));
    vt.push_back(mk(0,2,2, 9,1,0,7,0, C0, 4'b0000));
    vt.push_back(mk(0,0,0, 0,0,0,1,0, ST, 4'b1000));
    vt.push_back(mk(0,0,0, 0,0,0,1,0, ST, 4'b0100));
    vt.push_back(mk(0,0,0, 0,0,0,1,0, ST, 4'b0000));
    vt.push_back(NOP); vt.push_back(NOP);

    reset = 1'b0;
    drive(NOP);
    repeat (2) @(negedge clk);
    #1 chk("reset_idle", C0, 4'b0000);
    branch_taken_e = 1'b1;
    #1 chk("reset_branch", BR, 4'b0000);
    branch_taken_e = 1'b0;
    @(negedge clk) reset = 1'b1;

    foreach (vt[k]) begin
      @(negedge clk);
      drive(vt[k]);
      #1 chk($sformatf("table[%0d]", k), vt[k].ectl, vt[k].efwd);
    end

    // async reset in the middle of a latency-4 op
    @(negedge clk); drive(mk(0,0,0, 8,1,0,1,0, C0, 0));
    #1 chk("mid_a", C0, 4'b0000);
    @(negedge clk); drive(mk(8,0,1, 9,1,0,4,0, C0, 0));
    #1 chk("mid_x", C0, 4'b0000);
    @(negedge clk); drive(NOP);
    #1 chk("mid_busy", ST, 4'b0010);
    #1 reset = 1'b0;
    #1 chk("mid_reset", C0, 4'b0000);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); drive(mk(0,0,0, 3,1,0,1,0, C0, 0));
    #1 chk("resume_w", C0, 4'b0000);
    @(negedge clk); drive(mk(3,0,1, 4,1,0,1,0, C0, 0));
    #1 chk("resume_r", C0, 4'b0000);
    @(negedge clk); drive(NOP);
    #1 chk("resume_fwd", C0, 4'b0010);

    // random traffic vs model, starting from a clean reset
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    me = '{ra0:0, ra1:0, wa:0, u0:0, u1:0, rw:0, ld:0, left:1};
    mm = '{wa:0, rw:0};
    mw = '{wa:0, rw:0};
    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      bit busy, lu, br;
      int lnorm;
      m_e_t ne;
      @(negedge clk);
      v = mk(rreg(), rreg(), int'($urandom_range(0, 3)), rreg(),
             int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 1,
             int'($urandom_range(0, 9) == 0), C0, 4'b0000);
      drive(v);
      busy = (me.left > 1);
      lu = me.ld && me.rw && !busy &&
           ((v.u[0] && v.ra0 == me.wa) || (v.u[1] && v.ra1 == me.wa));
      br = v.br && !busy;
      v.ectl = {busy || (lu && !br), busy || (lu && !br), br, br || lu, busy, busy};
      v.efwd = {mfwd(me.ra1, me.u1), mfwd(me.ra0, me.u0)};
      #1 chk($sformatf("rand[%0d]", c), v.ectl, v.efwd);
      mw = mm;
      if (busy) begin
        me.left--;
        mm.rw = 1'b0;
      end else begin
        mm = '{wa:me.wa, rw:me.rw};
        lnorm = (v.lat == 0) ? 1 : (v.lat > 4) ? 4 : int'(v.lat);
        ne = '{ra0:v.ra0, ra1:v.ra1, wa:v.wa, u0:v.u[0], u1:v.u[1], rw:v.rw, ld:v.ld, left:lnorm};
        if (br || lu) ne = '{ra0:me.ra0, ra1:me.ra1, wa:me.wa, u0:0, u1:0, rw:0, ld:0, left:1};
        me = ne;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
